// File: rtl/pipeline_types.sv
// Pipeline register layouts and the MEM-stage FSM state type.
package pipeline_types;

  localparam int unsigned RegWidth = 32;

  typedef struct packed {
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]          addr;
    logic [RegWidth-1:0] value;
  } reg_wr_t;

  typedef struct packed {
    ctrl_t               ctrl;
    logic [RegWidth-1:0] rs;
    reg_wr_t             rd;
  } ex_mem_t;

  typedef struct packed {
    reg_wr_t rd;
    ctrl_t   ctrl;
    logic    fault;
  } mem_wb_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mem_state_e;

endpackage

// File: rtl/rv32_isa.sv
// RV32 load/store func3 encodings and the alignment rule shared by the MEM stage.
package rv32_isa;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_f3_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: is_misaligned = lo[0];
      F3_W:        is_misaligned = (lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module mem_load_fmt
  import rv32_isa::*;
(
  input  logic [31:0] iData,
  input  logic [1:0]  iAddrLo,
  input  logic [2:0]  iFunc3,
  output logic [31:0] oValue
);

  logic [31:0] shifted;
  logic [15:0] half;

  always_comb begin
    shifted = iData >> {iAddrLo, 3'b000};
    half    = iAddrLo[1] ? iData[31:16] : iData[15:0];
    case (iFunc3)
      F3_B:    oValue = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   oValue = {24'h0, shifted[7:0]};
      F3_H:    oValue = {{16{half[15]}}, half};
      F3_HU:   oValue = {16'h0, half};
      default: oValue = iData;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-outstanding data-bus access with IDLE/BUSY/DONE handshake.
module mem_stage
  import pipeline_types::*;
  import rv32_isa::*;
(
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iEn,
  input  logic                iStall,
  input  ex_mem_t             iEX,
  output mem_wb_t             oWB,
  output logic                oStall,
  output logic [RegWidth-1:0] oFwMe,
  output logic                oDbReq,
  output logic                oDbWe,
  output logic [31:0]         oDbAddr,
  output logic [31:0]         oDbWData,
  output logic [3:0]          oDbBe,
  input  logic                iDbAck,
  input  logic [31:0]         iDbRData,
  input  logic                iDbErr
);

  mem_state_e  state_q, state_d;
  mem_wb_t     wb_q, wb_d;
  ctrl_t       op_ctrl_q, op_ctrl_d;
  reg_wr_t     op_rd_q, op_rd_d;
  logic        db_req_q, db_req_d;
  logic        db_we_q, db_we_d;
  logic [31:0] db_addr_q, db_addr_d;
  logic [31:0] db_wdata_q, db_wdata_d;
  logic [3:0]  db_be_q, db_be_d;
  logic        stall_c;
  logic        is_mem;
  logic [31:0] load_val;

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs);
    case (f3)
      F3_B:    store_data = {4{rs[7:0]}};
      F3_H:    store_data = {2{rs[15:0]}};
      default: store_data = rs;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: lane_be = 4'b0001 << lo;
      F3_H, F3_HU: lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default:     lane_be = 4'b1111;
    endcase
  endfunction

  mem_load_fmt u_load_fmt (
    .iData   (iDbRData),
    .iAddrLo (op_rd_q.value[1:0]),
    .iFunc3  (op_ctrl_q.func3),
    .oValue  (load_val)
  );

  assign is_mem = iEX.ctrl.mem_rd | iEX.ctrl.mem_wr;

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    op_ctrl_d  = op_ctrl_q;
    op_rd_d    = op_rd_q;
    db_req_d   = db_req_q;
    db_we_d    = db_we_q;
    db_addr_d  = db_addr_q;
    db_wdata_d = db_wdata_q;
    db_be_d    = db_be_q;
    stall_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iEn && !iStall) begin
          if (is_mem && !is_misaligned(iEX.ctrl.func3, iEX.rd.value[1:0])) begin
            stall_c    = 1'b1;
            state_d    = S_BUSY;
            op_ctrl_d  = iEX.ctrl;
            op_rd_d    = iEX.rd;
            db_req_d   = 1'b1;
            db_we_d    = iEX.ctrl.mem_wr;
            db_addr_d  = {iEX.rd.value[31:2], 2'b00};
            db_wdata_d = store_data(iEX.ctrl.func3, iEX.rs);
            db_be_d    = lane_be(iEX.ctrl.func3, iEX.rd.value[1:0]);
          end else begin
            // A memory op reaching this branch is misaligned: retire it as a fault.
            wb_d.rd    = iEX.rd;
            wb_d.ctrl  = iEX.ctrl;
            wb_d.fault = is_mem;
          end
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (iDbAck) begin
          db_req_d        = 1'b0;
          wb_d.rd.addr    = op_rd_q.addr;
          wb_d.rd.value   = op_ctrl_q.mem_rd ? load_val : op_rd_q.value;
          wb_d.ctrl       = op_ctrl_q;
          wb_d.ctrl.reg_we = op_ctrl_q.reg_we & ~op_ctrl_q.mem_wr;
          wb_d.fault      = iDbErr;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        // EX sees the release only once WB can accept, so the low cycle is not lost.
        stall_c = iStall;
        if (!iStall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      wb_q       <= '0;
      op_ctrl_q  <= '0;
      op_rd_q    <= '0;
      db_req_q   <= 1'b0;
      db_we_q    <= 1'b0;
      db_addr_q  <= '0;
      db_wdata_q <= '0;
      db_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      op_ctrl_q  <= op_ctrl_d;
      op_rd_q    <= op_rd_d;
      db_req_q   <= db_req_d;
      db_we_q    <= db_we_d;
      db_addr_q  <= db_addr_d;
      db_wdata_q <= db_wdata_d;
      db_be_q    <= db_be_d;
    end
  end

  assign oWB      = wb_q;
  assign oFwMe    = wb_q.rd.value;
  assign oStall   = nRst & stall_c;
  assign oDbReq   = db_req_q;
  assign oDbWe    = db_we_q;
  assign oDbAddr  = db_addr_q;
  assign oDbWData = db_wdata_q;
  assign oDbBe    = db_be_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: iClk  in  1  pipeline clock (rising edge).
REQ-002 SHALL have: nRst  in  1  asynchronous active-low reset.
REQ-003 SHALL have: iEn  in  1  stage enable; when low no new memory request starts.
REQ-004 SHALL have: iStall  in  1  downstream (WB) stall; when high oWB holds.
REQ-005 SHALL have: iEX  in  ex_mem_t  EX/MEM register (ctrl, rs = store operand, rd.addr, rd.value = ALU result/address).
REQ-006 SHALL have: oWB  out  mem_wb_t  MEM/WB register (rd.addr, rd.value, ctrl, fault).
REQ-007 SHALL have: oStall  out  1  upstream stall request to IF/ID/EX.
REQ-008 SHALL have: oFwMe  out  RegWidth  forwarding value (= oWB.rd.value) for the EX bypass.
REQ-009 SHALL have data-bus ports: oDbReq out 1, oDbWe out 1, oDbAddr out 32, oDbWData out 32, oDbBe out 4, iDbAck in 1, iDbRData in 32, iDbErr in 1.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 Non-memory op in IDLE, iStall low: oWB <= {iEX.ctrl, iEX.rd.addr, iEX.rd.value, fault=0} at next edge; latency 1; oStall low.
REQ-012 Load/store in IDLE with iEn high and aligned address: latch oDbAddr = rd.value with low 2 bits cleared, oDbWe, oDbBe, oDbWData; oDbReq <= 1; go BUSY; oStall high combinationally in that cycle.
REQ-013 Store data/byte-enables: SB replicates rs[7:0] to all lanes, BE = 1<<addr[1:0]; SH replicates rs[15:0], BE = 4'b0011 or 4'b1100 by addr[1]; SW BE = 4'b1111.
REQ-014 BUSY: oDbReq and all bus outputs held stable until iDbAck; oStall high.
REQ-015 iDbAck in BUSY: oDbReq <= 0; oWB loaded (loads: formatted read data; stores: rd.value, write suppressed via ctrl); fault = iDbErr; go DONE.
REQ-016 Load formatting: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes word.
REQ-017 DONE: oStall low for exactly one cycle when iStall low, letting EX advance; then IDLE. If iStall high, remain DONE, oWB held.
REQ-018 Misaligned access (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus request; oWB loaded with fault=1 in 1 cycle as REQ-011.
REQ-019 iDbAck outside BUSY SHALL be ignored; iDbErr sampled only with iDbAck.
REQ-020 iStall high in IDLE: oWB holds; new request still MAY NOT start (oStall follows REQ-012 only when iStall low).
REQ-021 iEn low: FSM stays IDLE, no request, oWB holds.

Reset
REQ-022 nRst low SHALL asynchronously force: state IDLE, oWB = '0, oDbReq = 0, oDbWe = 0, oDbBe = 0, oDbAddr = 0, oDbWData = 0.
REQ-023 Reset mid-transaction (BUSY) SHALL drop oDbReq immediately; a later iDbAck SHALL be ignored.
REQ-024 oStall SHALL be 0 during reset.

Structure
REQ-025 mem_wb_t and the FSM state enum SHALL live in pipeline_types; load/store func3 encodings in rv32_isa.
REQ-026 Load extraction/extension SHALL be a combinational sub-module mem_load_fmt (iData, iAddrLo, iFunc3 -> oValue).
REQ-027 Total RTL 120-400 lines.

Verification
REQ-028 ADD result 0x0000_0010 to rd=5, no mem -> oWB.rd = {5, 0x10} one edge later, oDbReq never high.
REQ-029 LB addr 0x1003, iDbRData 0x80xx_xxxx, ack after 3 wait cycles -> oStall high 4 cycles+, oWB.rd.value = 0xFFFF_FF80, then one DONE cycle with oStall low.
REQ-030 SH addr 0x2002, rs = 0x1234_ABCD -> oDbWe=1, oDbBe=4'b1100, oDbWData=0xABCD_ABCD, oDbAddr=0x2000.
REQ-031 LW addr 0x3001 -> no oDbReq, oWB.fault=1 after 1 cycle.
REQ-032 nRst pulsed low while BUSY, then iDbAck -> oDbReq 0 immediately, oWB = 0, state IDLE, ack ignored.
REQ-033 LHU ack with iDbErr=1 and iStall high in DONE -> oWB.fault=1, oStall low only after iStall drops, single cycle.
